scan_carriage_driver: RTL and testbench

- Upstream motion stage for sensor_scan.
- Turns the one-cycle scan_offset_move / scan_move requests into stepper-motor coil sequences that move the sensor bar one board row.
- Homes the bar against a limit switch before the offset move.
- Returns a one-cycle scan_move_done pulse once the bar has reached position and sensor settle time has elapsed.

---
 rtl/carscan_pkg.sv | 26 ++
 rtl/scan_carriage_driver_if.sv | 26 ++
 rtl/scan_carriage_driver_step_tick_gen.sv | 29 ++
 rtl/scan_carriage_driver.sv | 144 ++++++++++++++
 tb/tb_scan_carriage_driver.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/carscan_pkg.sv
// Shared definitions for the scan carriage driver: FSM state encoding,
// full-step coil phase table and default timing constants.
package carscan_pkg;

    localparam int unsigned STEP_CNT_W = 16;

    localparam int unsigned DEF_STEP_DIV       = 50000;
    localparam int unsigned DEF_ROW_STEPS      = 200;
    localparam int unsigned DEF_OFFSET_STEPS   = 100;
    localparam int unsigned DEF_HOME_MAX_STEPS = 4000;
    localparam int unsigned DEF_SETTLE_CYC     = 500000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOME,
        ST_OFFSET,
        ST_ROW,
        ST_SETTLE,
        ST_DONE,
        ST_FAULT
    } state_t;

    // Entry [i] is the coil pattern for phase index i (index 0 = 0011).
    localparam logic [3:0][3:0] COIL_TBL = {4'b1001, 4'b1100, 4'b0110, 4'b0011};

endpackage

// File: rtl/scan_carriage_driver_if.sv
// Request/done handshake between sensor_scan (master) and the carriage
// driver (slave).
//   scan_offset_move : one-cycle request, home then move to first row
//   scan_move        : one-cycle request, advance one row
//   scan_move_done   : one-cycle pulse, move complete and settled
//   busy             : driver is executing a move
interface scan_carriage_driver_if;
    logic scan_offset_move;
    logic scan_move;
    logic scan_move_done;
    logic busy;

    modport master (
        output scan_offset_move,
        output scan_move,
        input  scan_move_done,
        input  busy
    );

    modport slave (
        input  scan_offset_move,
        input  scan_move,
        output scan_move_done,
        output busy
    );
endinterface

// File: rtl/scan_carriage_driver_step_tick_gen.sv
// Step-rate divider: counts 0..DIV-1 and flags the last count as a tick.
//   clk, reset_n : clock, synchronous active-low reset
//   clr          : synchronous clear of the count
//   tick_c       : high for the cycle the count equals DIV-1
module step_tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic tick_c
);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick_c = (cnt == CNT_W'(DIV - 1));

    // Divider count; wraps on tick, restarts on clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr || tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/scan_carriage_driver.sv
// Stepper carriage driver for sensor_scan: homes against a limit switch,
// steps the bar forward by an offset or one row, holds for settle time,
// then pulses scan_move_done.
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : request/done/busy handshake (slave side)
//   home_sw      : home limit switch, asynchronous, active high
//   coil         : full-step two-phase coil drive
//   motor_en     : driver enable
//   fault        : sticky homing failure
module scan_carriage_driver
    import carscan_pkg::*;
#(
    parameter int unsigned STEP_DIV       = DEF_STEP_DIV,
    parameter int unsigned ROW_STEPS      = DEF_ROW_STEPS,
    parameter int unsigned OFFSET_STEPS   = DEF_OFFSET_STEPS,
    parameter int unsigned HOME_MAX_STEPS = DEF_HOME_MAX_STEPS,
    parameter int unsigned SETTLE_CYC     = DEF_SETTLE_CYC
) (
    input  logic                  clk,
    input  logic                  reset_n,
    scan_carriage_driver_if.slave bus,
    input  logic                  home_sw,
    output logic [3:0]            coil,
    output logic                  motor_en,
    output logic                  fault
);
    localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t                  state, state_n;
    logic [STEP_CNT_W-1:0]   step_cnt, step_cnt_n, step_inc;
    logic [1:0]              phase, phase_n;
    logic [SET_W-1:0]        set_cnt, set_cnt_n;
    logic                    hs_meta, hs;
    logic                    tick_c, div_clr;
    logic                    en_n;
    logic                    done_q, busy_q;

    assign bus.scan_move_done = done_q;
    assign bus.busy           = busy_q;
    assign step_inc           = step_cnt + STEP_CNT_W'(1);

    step_tick_gen #(.DIV(STEP_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (div_clr),
        .tick_c  (tick_c)
    );

    // Two-flop synchroniser for the home switch.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hs_meta <= 1'b0;
            hs      <= 1'b0;
        end else begin
            hs_meta <= home_sw;
            hs      <= hs_meta;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            step_cnt <= '0;
            phase    <= 2'd0;
            set_cnt  <= '0;
            coil     <= 4'b0000;
            motor_en <= 1'b0;
            fault    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            step_cnt <= step_cnt_n;
            phase    <= phase_n;
            set_cnt  <= set_cnt_n;
            coil     <= en_n ? COIL_TBL[phase_n] : 4'b0000;
            motor_en <= en_n;
            fault    <= (state_n == ST_FAULT);
            done_q   <= (state_n == ST_DONE);
            busy_q   <= !(state_n inside {ST_IDLE, ST_FAULT});
        end
    end

    // Next-state, step/phase/settle bookkeeping.
    always_comb begin
        state_n    = state;
        step_cnt_n = step_cnt;
        phase_n    = phase;
        set_cnt_n  = set_cnt;

        unique case (state)
            ST_IDLE: begin
                step_cnt_n = '0;
                set_cnt_n  = '0;
                if (bus.scan_offset_move) begin
                    state_n = hs ? ST_OFFSET : ST_HOME;
                end else if (bus.scan_move) begin
                    state_n = ST_ROW;
                end
            end
            ST_HOME: begin
                if (tick_c) begin
                    if (hs) begin
                        // Switch reached: skip this reverse step and start the offset run.
                        state_n    = ST_OFFSET;
                        step_cnt_n = '0;
                    end else begin
                        phase_n    = phase - 2'd1;
                        step_cnt_n = step_inc;
                        if (step_inc == STEP_CNT_W'(HOME_MAX_STEPS)) begin
                            state_n = ST_FAULT;
                        end
                    end
                end
            end
            ST_OFFSET, ST_ROW: begin
                if (tick_c) begin
                    phase_n    = phase + 2'd1;
                    step_cnt_n = step_inc;
                    if (step_inc == STEP_CNT_W'((state == ST_ROW) ? ROW_STEPS : OFFSET_STEPS)) begin
                        state_n    = ST_SETTLE;
                        step_cnt_n = '0;
                    end
                end
            end
            ST_SETTLE: begin
                if (set_cnt == SET_W'(SETTLE_CYC - 1)) begin
                    state_n   = ST_DONE;
                    set_cnt_n = '0;
                end else begin
                    set_cnt_n = set_cnt + SET_W'(1);
                end
            end
            ST_DONE:  state_n = ST_IDLE;
            ST_FAULT: state_n = ST_FAULT;
            default:  state_n = ST_IDLE;
        endcase

        // Divider restarts on every state change and idles outside motion states.
        div_clr = (state_n != state) || !(state inside {ST_HOME, ST_OFFSET, ST_ROW});
        en_n    = (state_n inside {ST_HOME, ST_OFFSET, ST_ROW, ST_SETTLE, ST_DONE});
    end
endmodule

// File: tb/tb_scan_carriage_driver.sv
// Self-checking bench for scan_carriage_driver with small timing parameters.
// Expected outputs come from closed-form per-cycle schedules of each move.
module tb_scan_carriage_driver;
    localparam int D = 4;   // STEP_DIV
    localparam int R = 3;   // ROW_STEPS
    localparam int O = 2;   // OFFSET_STEPS
    localparam int S = 5;   // SETTLE_CYC
    localparam int H = 8;   // HOME_MAX_STEPS

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       home_sw = 1'b0;
    logic [3:0] coil;
    logic       motor_en;
    logic       fault;

    int checks = 0;
    int failures = 0;
    int phase = 0;

    scan_carriage_driver_if bus ();

    scan_carriage_driver #(
        .STEP_DIV       (D),
        .ROW_STEPS      (R),
        .OFFSET_STEPS   (O),
        .HOME_MAX_STEPS (H),
        .SETTLE_CYC     (S)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .home_sw  (home_sw),
        .coil     (coil),
        .motor_en (motor_en),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] tbl(input int idx);
        int m;
        m = ((idx % 4) + 4) % 4;
        case (m)
            0: return 4'b0011;
            1: return 4'b0110;
            2: return 4'b1100;
            default: return 4'b1001;
        endcase
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input int c, input logic [3:0] e_coil,
                               input logic e_en, input logic e_busy, input logic e_done,
                               input logic e_fault);
        check($sformatf("%s c%0d coil", tag, c), coil, e_coil);
        check($sformatf("%s c%0d motor_en", tag, c), {3'b0, motor_en}, {3'b0, e_en});
        check($sformatf("%s c%0d busy", tag, c), {3'b0, bus.busy}, {3'b0, e_busy});
        check($sformatf("%s c%0d done", tag, c), {3'b0, bus.scan_move_done}, {3'b0, e_done});
        check($sformatf("%s c%0d fault", tag, c), {3'b0, fault}, {3'b0, e_fault});
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_cycle(tag, i, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_cycle("reset", i, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        reset_n = 1'b1;
        phase = 0;
    endtask

    // One request issued at cycle 0; outputs checked every cycle against the
    // schedule. raise_at: cycle home_sw is driven high (-1 none); abort_at:
    // cycle reset_n is pulsed low (-1 none); drop_en: one extra request while busy.
    task automatic do_move(input bit offset, input bit both, input int raise_at,
                           input bit drop_en, input int abort_at, input string tag);
        bit hs0, flt, drop_off;
        int k, home_len, back, fs, nf, done_c, total, drop_at, p, pb;
        logic [3:0] e_coil;
        logic e_en, e_busy, e_done, e_fault;

        hs0 = home_sw;
        p = phase;
        flt = 1'b0;
        home_len = 0;
        back = 0;
        if (offset && !hs0) begin
            k = 0;
            for (int j = 1; j <= H; j++) begin
                if (k == 0 && raise_at >= 0 && j * D >= raise_at + 2) k = j;
            end
            flt = (k == 0);
            home_len = flt ? H * D : k * D;
            back = flt ? H : k - 1;
        end
        pb = p - back;
        fs = home_len + 1;
        nf = offset ? O : R;
        done_c = fs + nf * D + S;
        if (abort_at >= 0) total = abort_at + 25;
        else if (flt) total = home_len + 12;
        else total = done_c + 3;
        drop_at = -1;
        if (drop_en) drop_at = $urandom_range(1, flt ? home_len + 10 : done_c);
        drop_off = 1'($urandom_range(0, 1));

        for (int c = 0; c <= total; c++) begin
            @(negedge clk);
            e_coil = 4'b0000; e_en = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_fault = 1'b0;
            if (abort_at >= 0 && c > abort_at) begin
                e_en = 1'b0;
            end else if (c >= 1 && c <= home_len) begin
                e_en = 1'b1; e_busy = 1'b1; e_coil = tbl(p - (c - 1) / D);
            end else if (flt && c > home_len) begin
                e_fault = 1'b1;
            end else if (c >= fs && c < fs + nf * D) begin
                e_en = 1'b1; e_busy = 1'b1; e_coil = tbl(pb + (c - fs) / D);
            end else if (c >= fs + nf * D && c <= done_c) begin
                e_en = 1'b1; e_busy = 1'b1; e_coil = tbl(pb + nf); e_done = (c == done_c);
            end
            check_cycle(tag, c, e_coil, e_en, e_busy, e_done, e_fault);

            bus.scan_move        = (c == 0 && (!offset || both)) || (c == drop_at);
            bus.scan_offset_move = (c == 0 && offset) || (c == drop_at && drop_off);
            if (c == raise_at) home_sw = 1'b1;
            reset_n = (c == abort_at) ? 1'b0 : 1'b1;
        end
        bus.scan_move = 1'b0;
        bus.scan_offset_move = 1'b0;
        reset_n = 1'b1;

        if (abort_at >= 0) phase = 0;
        else if (flt) phase = p - H;
        else phase = pb + nf;
    endtask

    initial begin
        int kind;
        bus.scan_move = 1'b0;
        bus.scan_offset_move = 1'b0;

        do_reset();
        idle(3, "post_reset");

        // Row move from phase 0.
        do_move(1'b0, 1'b0, -1, 1'b0, -1, "row");

        // Homing: switch rises after three reverse steps.
        phase = 0;
        do_reset();
        home_sw = 1'b0;
        idle(3, "pre_home");
        do_move(1'b1, 1'b0, 13, 1'b0, -1, "home");

        // Homing fault; an extra request during/after fault must be ignored.
        home_sw = 1'b0;
        idle(3, "pre_fault");
        do_move(1'b1, 1'b0, -1, 1'b1, -1, "fault");
        do_reset();

        // Collision with switch already made, plus a dropped mid-move request.
        home_sw = 1'b1;
        idle(3, "pre_coll");
        do_move(1'b1, 1'b1, -1, 1'b1, -1, "collision");

        // Abort during ROW after the first step.
        idle(2, "pre_abort");
        do_move(1'b0, 1'b0, -1, 1'b0, 5, "abort");

        // Randomised sequence of moves.
        for (int it = 0; it < 12; it++) begin
            kind = $urandom_range(0, 2);
            home_sw = (kind == 2) ? 1'b0 : ((kind == 1) ? 1'b1 : 1'($urandom_range(0, 1)));
            idle(3, $sformatf("rnd%0d_pre", it));
            if (kind == 0) begin
                do_move(1'b0, 1'b0, -1, 1'($urandom_range(0, 1)), -1, $sformatf("rnd%0d_row", it));
            end else if (kind == 1) begin
                do_move(1'b1, 1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)), -1,
                        $sformatf("rnd%0d_off", it));
            end else begin
                do_move(1'b1, 1'($urandom_range(0, 1)), $urandom_range(1, H * D + 4),
                        1'($urandom_range(0, 1)), -1, $sformatf("rnd%0d_home", it));
                if (fault === 1'b1) do_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
